// File: rtl/ram_bist_ctrl_pkg.sv
// Shared types for the RAM BIST initiator:
// FSM state encoding, saturation limit and the test pattern.
package ram_bist_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [7:0] ERR_SAT = 8'hFF;

   // Callers truncate the result to their data width.
   function automatic logic [31:0] pattern(
      input logic [31:0] a,
      input logic [31:0] seed
   );
      return a ^ seed;
   endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// BIST initiator for a single-port RAM with registered read: writes
// pattern(a) over [ADDR_LO,ADDR_HI], reads it back and compares.
// Ports: clk, rst (sync, active high), start; ram_dout in;
// ram_din/ram_addr/ram_cs/ram_we to the RAM; busy, done (pulse),
// pass, err_count (saturating), first_err_addr as run results.
module ram_bist_ctrl
   import ram_bist_ctrl_pkg::*;
#(
   parameter int            AW      = 8,
   parameter int            DW      = 8,
   parameter int            ADDR_LO = 0,
   parameter int            ADDR_HI = 255,
   parameter logic [DW-1:0] SEED    = DW'(8'hA5)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] ram_dout,
   output logic [DW-1:0] ram_din,
   output logic [AW-1:0] ram_addr,
   output logic          ram_cs,
   output logic          ram_we,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [7:0]    err_count,
   output logic [AW-1:0] first_err_addr
);

   localparam logic [AW-1:0] LO = AW'(ADDR_LO);
   localparam logic [AW-1:0] HI = AW'(ADDR_HI);

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return DW'(pattern(32'(a), 32'(SEED)));
   endfunction

   state_t        state, nxt;
   logic          drain_cnt;
   logic          tag_vld;
   logic [DW-1:0] tag_exp;
   logic [AW-1:0] tag_addr;

   logic          d_cs, d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_din;
   logic [AW-1:0] addr_inc;
   logic          mis;
   logic          go;

   assign addr_inc = ram_addr + AW'(1);
   assign go       = (state == S_IDLE) && start;
   // X on the read bus is treated as a mismatch.
   assign mis      = tag_vld && (ram_dout !== tag_exp);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         drain_cnt      <= 1'b0;
         tag_vld        <= 1'b0;
         tag_exp        <= '0;
         tag_addr       <= '0;
         ram_cs         <= 1'b0;
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_din        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         state     <= nxt;
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         ram_cs    <= d_cs;
         ram_we    <= d_we;
         ram_addr  <= d_addr;
         ram_din   <= d_din;
         busy      <= (nxt == S_WRITE) || (nxt == S_READ) ||
                      (nxt == S_DRAIN);
         done      <= (nxt == S_DONE);
         // Tag follows the read presented this cycle; its data
         // arrives one edge later.
         tag_vld   <= ram_cs && !ram_we;
         tag_exp   <= pat(ram_addr);
         tag_addr  <= ram_addr;
         if (go) begin
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
         end else begin
            if (mis) begin
               if (err_count != ERR_SAT)
                  err_count <= err_count + 8'd1;
               if (err_count == 8'd0)
                  first_err_addr <= tag_addr;
            end
            if (nxt == S_DONE)
               pass <= (err_count == 8'd0);
         end
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = S_WRITE;
         S_WRITE: if (ram_addr == HI) nxt = S_READ;
         S_READ:  if (ram_addr == HI) nxt = S_DRAIN;
         S_DRAIN: if (drain_cnt) nxt = S_DONE;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      d_cs   = 1'b0;
      d_we   = 1'b0;
      d_addr = ram_addr;
      d_din  = ram_din;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               d_cs   = 1'b1;
               d_we   = 1'b1;
               d_addr = LO;
               d_din  = pat(LO);
            end
         end
         S_WRITE: begin
            d_cs = 1'b1;
            if (ram_addr == HI) begin
               d_addr = LO;
            end else begin
               d_we   = 1'b1;
               d_addr = addr_inc;
               d_din  = pat(addr_inc);
            end
         end
         S_READ: begin
            if (ram_addr != HI) begin
               d_cs   = 1'b1;
               d_addr = addr_inc;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a 256x8 RAM model
// carrying per-address and/or/xor read faults.
module tb_ram_bist_ctrl;

   localparam int N      = 256;
   localparam int LO     = 0;
   localparam int DONE_K = 2 * N + 3;
   localparam int LIMIT  = 700;

   logic clk, rst, start, start2;

   logic [7:0] dout, din, addr, err;
   logic       cs, we, busy, done, pass;
   logic [7:0] first;

   logic [7:0] dout2, din2, addr2, err2;
   logic       cs2, we2, busy2, done2, pass2;
   logic [7:0] first2;

   ram_bist_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .ram_dout(dout), .ram_din(din), .ram_addr(addr),
      .ram_cs(cs), .ram_we(we), .busy(busy), .done(done),
      .pass(pass), .err_count(err), .first_err_addr(first)
   );

   ram_bist_ctrl #(.ADDR_LO(131), .ADDR_HI(131)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .ram_dout(dout2), .ram_din(din2), .ram_addr(addr2),
      .ram_cs(cs2), .ram_we(we2), .busy(busy2), .done(done2),
      .pass(pass2), .err_count(err2), .first_err_addr(first2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tot = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // RAM models
   logic [7:0] mem [256];
   logic [7:0] and_m [256];
   logic [7:0] or_m [256];
   logic [7:0] xr_m [256];

   always @(posedge clk) begin
      if (cs) begin
         if (we) mem[addr] <= din;
         else dout <= ((mem[addr] & and_m[addr]) | or_m[addr])
                      ^ xr_m[addr];
      end else begin
         dout <= 'x;
      end
   end

   logic [7:0] mem2 [256];
   int wr2 = 0;
   int rd2 = 0;
   int oob2 = 0;

   always @(posedge clk) begin
      if (cs2) begin
         if (addr2 != 8'h83) oob2 <= oob2 + 1;
         if (we2) begin
            mem2[addr2] <= din2;
            wr2 <= wr2 + 1;
         end else begin
            dout2 <= mem2[addr2];
            rd2 <= rd2 + 1;
         end
      end else begin
         dout2 <= 'x;
      end
   end

   int done_cnt = 0;
   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   // Reference model: a run is just a cycle index k since the start
   // edge (k=1); the expected outputs are read off the run layout.
   function automatic logic [7:0] bpat(input int a);
      return 8'(a) ^ 8'hA5;
   endfunction

   function automatic logic [7:0] rdval(input int a);
      return ((bpat(a) & and_m[a]) | or_m[a]) ^ xr_m[a];
   endfunction

   function automatic int nbad(input int last);
      int c = 0;
      for (int i = 0; i <= last; i++)
         if (rdval(LO + i) != bpat(LO + i)) c++;
      return c > 255 ? 255 : c;
   endfunction

   function automatic int fbad(input int last);
      for (int i = 0; i <= last; i++)
         if (rdval(LO + i) != bpat(LO + i)) return LO + i;
      return 0;
   endfunction

   int k = 0;
   int res_err = 0;
   int res_first = 0;
   int res_pass = 0;
   bit mon_on = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         k <= 0;
         res_err <= 0;
         res_first <= 0;
         res_pass <= 0;
      end else if (k == 0) begin
         if (start) begin
            k <= 1;
            res_err <= 0;
            res_first <= 0;
            res_pass <= 0;
         end
      end else if (k == DONE_K) begin
         k <= 0;
      end else begin
         k <= k + 1;
         if (k + 1 == DONE_K) begin
            res_err <= nbad(N - 1);
            res_first <= fbad(N - 1);
            res_pass <= (nbad(N - 1) == 0) ? 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         if (k >= 1 && k <= N) begin
            chk("wr_cs", cs, 1);
            chk("wr_we", we, 1);
            chk("wr_addr", addr, LO + k - 1);
            chk("wr_din", din, bpat(LO + k - 1));
         end else if (k > N && k <= 2 * N) begin
            chk("rd_cs", cs, 1);
            chk("rd_we", we, 0);
            chk("rd_addr", addr, LO + k - N - 1);
         end else begin
            chk("idle_cs", cs, 0);
            chk("idle_we", we, 0);
         end
         chk("busy", busy, (k >= 1 && k <= 2 * N + 2) ? 1 : 0);
         chk("done", done, (k == DONE_K) ? 1 : 0);
         if (k == 0 || k == DONE_K) begin
            chk("res_err", err, res_err);
            chk("res_first", first, res_first);
            chk("res_pass", pass, res_pass);
         end else begin
            chk("run_err", err, nbad(k - N - 3));
            chk("run_first", first, fbad(k - N - 3));
            chk("run_pass", pass, 0);
         end
      end
   end

   task automatic clear_faults();
      for (int i = 0; i < 256; i++) begin
         and_m[i] = 8'hFF;
         or_m[i]  = 8'h00;
         xr_m[i]  = 8'h00;
      end
   endtask

   int acc = 0;

   task automatic run_main(input bit noisy);
      int e;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e = 1;
      while (!done && e < LIMIT) begin
         @(negedge clk);
         e++;
         if (noisy) start = (e == 10);
      end
      start = 1'b0;
      chk("done_edge", e, DONE_K);
      acc++;
      if (noisy) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n, a, b;
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst_cs", cs, 0);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err, 0);
      chk("rst_first", first, 0);
      rst = 1'b0;
      mon_on = 1'b1;
      @(negedge clk);

      run_main(1'b0);
      chk("good_pass", pass, 1);
      chk("good_err", err, 0);
      chk("good_mem80", mem[8'h80], 8'h25);

      and_m[8'h10] = 8'hFE;
      run_main(1'b0);
      chk("sa0_pass", pass, 0);
      chk("sa0_err", err, 1);
      chk("sa0_first", first, 8'h10);

      clear_faults();
      for (int i = 0; i < 256; i++) or_m[i] = 8'h80;
      run_main(1'b0);
      chk("sa1_err", err, 8'h80);
      chk("sa1_first", first, 8'h80);

      clear_faults();
      for (int i = 0; i < 256; i++) xr_m[i] = 8'hFF;
      run_main(1'b0);
      chk("sat_err", err, 8'hFF);
      chk("sat_first", first, 8'h00);
      chk("sat_pass", pass, 0);

      clear_faults();
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("one_done_edge", n, 5);
      chk("one_pass", pass2, 1);
      chk("one_err", err2, 0);
      chk("one_mem", mem2[8'h83], 8'h26);
      chk("one_writes", wr2, 1);
      chk("one_reads", rd2, 1);
      chk("one_range", oob2, 0);
      repeat (3) @(negedge clk);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_we", we, 0);
      n = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_cs", cs, 0);
      chk("abort_busy", busy, 0);
      repeat (600) @(negedge clk);
      chk("abort_nodone", done_cnt, n);
      run_main(1'b0);
      chk("after_abort_pass", pass, 1);

      run_main(1'b1);
      repeat (20) @(negedge clk);
      chk("noisy_idle", busy, 0);
      chk("noisy_pass", pass, 1);

      for (int r = 0; r < 6; r++) begin
         clear_faults();
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 7);
            case ($urandom_range(0, 2))
               0: and_m[a] = ~(8'h01 << b);
               1: or_m[a] = 8'h01 << b;
               default: xr_m[a] = 8'($urandom);
            endcase
         end
         run_main(r[0]);
      end

      chk("done_pulses", done_cnt, acc);
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
